// File: rtl/counter_pkg.sv
// Shared types and constants for the multi-mode counter.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP_WRAP   = 2'b00,
    MODE_DOWN_WRAP = 2'b01,
    MODE_UP_SAT    = 2'b10,
    MODE_PINGPONG  = 2'b11
  } mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Direction implied by the modes whose direction never changes
  function automatic logic fixed_dir(mode_t m);
    return (m == MODE_DOWN_WRAP) ? DIR_DOWN : DIR_UP;
  endfunction

endpackage

// File: rtl/module_prescaler.sv
// Prescaler: emits a one-clock tick every DIV enabled clocks.
// clear_i restarts the period from zero (used by the counter's load).
module module_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] cnt;

  // Period counter: 0..DIV-1 while enabled, frozen when disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear_i) begin
      cnt <= '0;
    end else if (en_i) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + ONE;
    end
  end

  assign tick_o = en_i && (cnt == LAST);

endmodule

// File: rtl/module_counter_multimode.sv
// Multi-mode prescaled counter: up-wrap, down-wrap, up-saturate and
// ping-pong, with synchronous clamped load and a registered terminal pulse.
// Optional sticky overflow flag enabled by defining COUNTER_OVF_STICKY_EN.
module module_counter_multimode
  import counter_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int DIV     = 10,
  parameter int MAX_VAL = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef COUNTER_OVF_STICKY_EN
  input  logic             clr_ovf_i,
  output logic             ovf_o,
`endif
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             dir_o
);

  localparam logic [WIDTH-1:0] MAX     = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  mode_t            mode;
  logic             tick;
  logic [WIDTH-1:0] count_next;
  logic             dir_next;
  logic             tc_next;
  logic             step_down;

  assign mode = mode_t'(mode_i);

  module_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_i),
    .clear_i (load_i),
    .tick_o  (tick)
  );

  // Next count/direction/terminal pulse: load beats tick, otherwise hold
  always_comb begin
    count_next = count_o;
    dir_next   = dir_o;
    tc_next    = 1'b0;
    step_down  = 1'b0;
    if (load_i) begin
      count_next = ({1'b0, load_val_i} > MAX_EXT) ? MAX : load_val_i;
      if (mode == MODE_PINGPONG) begin
        if (count_next == MAX)      dir_next = DIR_DOWN;
        else if (count_next == '0)  dir_next = DIR_UP;
      end
    end else if (tick) begin
      unique case (mode)
        MODE_UP_WRAP: begin
          count_next = (count_o == MAX) ? '0 : count_o + ONE;
          dir_next   = fixed_dir(mode);
          tc_next    = (count_next == MAX);
        end
        MODE_DOWN_WRAP: begin
          count_next = (count_o == '0) ? MAX : count_o - ONE;
          dir_next   = fixed_dir(mode);
          tc_next    = (count_next == '0);
        end
        MODE_UP_SAT: begin
          count_next = (count_o == MAX) ? MAX : count_o + ONE;
          dir_next   = fixed_dir(mode);
          tc_next    = (count_o != MAX) && (count_next == MAX);
        end
        MODE_PINGPONG: begin
          if (count_o == MAX)      step_down = 1'b1;
          else if (count_o == '0)  step_down = 1'b0;
          else                     step_down = dir_o;
          count_next = step_down ? count_o - ONE : count_o + ONE;
          if (count_next == MAX)      dir_next = DIR_DOWN;
          else if (count_next == '0)  dir_next = DIR_UP;
          else                        dir_next = step_down;
          tc_next = (count_next == MAX) || (count_next == '0);
        end
      endcase
    end
  end

  // Registered count, direction and terminal-count pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      count_o <= '0;
      dir_o   <= DIR_UP;
      tc_o    <= 1'b0;
    end else begin
      count_o <= count_next;
      dir_o   <= dir_next;
      tc_o    <= tc_next;
    end
  end

`ifdef COUNTER_OVF_STICKY_EN
  // Sticky overflow: set alongside tc_o, set wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst)            ovf_o <= 1'b0;
    else if (tc_next)   ovf_o <= 1'b1;
    else if (clr_ovf_i) ovf_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_module_counter_multimode.sv
// Self-checking bench for module_counter_multimode: two configurations
// driven from shared stimulus, a behavioural model per instance, and a few
// directed sequences with literal expectations.
// Covers COUNTER_OVF_STICKY_EN when the macro is defined.
module tb_module_counter_multimode;

  typedef struct {
    int count;
    int dir;
    int tc;
    int pre;
    int ovf;
  } model_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ld;
  logic [3:0] ld_val_a;
  logic [2:0] ld_val_b;
  logic [1:0] mode;
  logic       clr_ovf;

  logic [3:0] count_a;
  logic       tc_a, dir_a;
  logic [2:0] count_b;
  logic       tc_b, dir_b;
`ifdef COUNTER_OVF_STICKY_EN
  logic       ovf_a, ovf_b;
`endif

  int vectors = 0;
  int miscompares = 0;

  model_t ma, mb;
  bit     model_valid = 0;

  module_counter_multimode #(.WIDTH(4), .DIV(1), .MAX_VAL(9)) dut_a (
    .clk        (clk),
    .rst        (rst),
`ifdef COUNTER_OVF_STICKY_EN
    .clr_ovf_i  (clr_ovf),
    .ovf_o      (ovf_a),
`endif
    .en_i       (en),
    .load_i     (ld),
    .load_val_i (ld_val_a),
    .mode_i     (mode),
    .count_o    (count_a),
    .tc_o       (tc_a),
    .dir_o      (dir_a)
  );

  module_counter_multimode #(.WIDTH(3), .DIV(4), .MAX_VAL(5)) dut_b (
    .clk        (clk),
    .rst        (rst),
`ifdef COUNTER_OVF_STICKY_EN
    .clr_ovf_i  (clr_ovf),
    .ovf_o      (ovf_b),
`endif
    .en_i       (en),
    .load_i     (ld),
    .load_val_i (ld_val_b),
    .mode_i     (mode),
    .count_o    (count_b),
    .tc_o       (tc_b),
    .dir_o      (dir_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural reference: one clock of the counter rules in plain integers
  function automatic model_t model_step(model_t s, int div, int maxv, bit r,
                                        bit e, bit l, int lv, int md, bit clr);
    model_t n;
    bit     tick;
    int     d;
    n = s;
    n.tc = 0;
    if (r) begin
      n = '{0, 0, 0, 0, 0};
      return n;
    end
    tick = e && (s.pre == div - 1);
    if (l)      n.pre = 0;
    else if (e) n.pre = (s.pre + 1) % div;
    if (l) begin
      n.count = (lv > maxv) ? maxv : lv;
      if (md == 3) n.dir = (n.count == maxv) ? 1 : (n.count == 0) ? 0 : s.dir;
    end else if (tick) begin
      case (md)
        0: begin
          n.count = (s.count + 1) % (maxv + 1);
          n.dir = 0;
          n.tc = (n.count == maxv);
        end
        1: begin
          n.count = (s.count + maxv) % (maxv + 1);
          n.dir = 1;
          n.tc = (n.count == 0);
        end
        2: begin
          n.count = (s.count < maxv) ? s.count + 1 : maxv;
          n.dir = 0;
          n.tc = (s.count != maxv) && (n.count == maxv);
        end
        default: begin
          d = (s.count == maxv) ? -1 : (s.count == 0) ? 1 : (s.dir != 0 ? -1 : 1);
          n.count = s.count + d;
          n.dir = (n.count == maxv) ? 1 : (n.count == 0) ? 0 : (d < 0 ? 1 : 0);
          n.tc = (n.count == maxv) || (n.count == 0);
        end
      endcase
    end
    if (n.tc != 0) n.ovf = 1;
    else if (clr)  n.ovf = 0;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit l,
                               input logic [3:0] va, input logic [2:0] vb,
                               input logic [1:0] m, input bit c);
    rst = r;
    en = e;
    ld = l;
    ld_val_a = va;
    ld_val_b = vb;
    mode = m;
    clr_ovf = c;
    @(negedge clk);
  endtask

  // Advance both models on every rising edge using the inputs seen there
  always @(posedge clk) begin
    ma = model_step(ma, 1, 9, rst, en, ld, int'(ld_val_a), int'(mode), clr_ovf);
    mb = model_step(mb, 4, 5, rst, en, ld, int'(ld_val_b), int'(mode), clr_ovf);
    if (rst) model_valid = 1;
  end

  // Compare both instances against the models each falling edge
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("a_count", 32'(count_a), ma.count);
      checkOutput("a_tc",    32'(tc_a),    ma.tc);
      checkOutput("a_dir",   32'(dir_a),   ma.dir);
      checkOutput("b_count", 32'(count_b), mb.count);
      checkOutput("b_tc",    32'(tc_b),    mb.tc);
      checkOutput("b_dir",   32'(dir_b),   mb.dir);
`ifdef COUNTER_OVF_STICKY_EN
      checkOutput("a_ovf",   32'(ovf_a),   ma.ovf);
      checkOutput("b_ovf",   32'(ovf_b),   mb.ovf);
`endif
    end
  end

  initial begin
    int p;
    int exp_cnt;
    logic [1:0] cur_mode;
    rst = 1'b1; en = 1'b0; ld = 1'b0; ld_val_a = '0; ld_val_b = '0;
    mode = 2'b00; clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_count", 32'(count_a), 0);
    checkOutput("reset_tc",    32'(tc_a),    0);
    checkOutput("reset_dir",   32'(dir_a),   0);

    // UP_WRAP with DIV=1: 1..9 then 0, pulse only on 9
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 1, 0, 4'd0, 3'd0, 2'b00, 0);
      checkOutput("upwrap_count", 32'(count_a), i % 10);
      checkOutput("upwrap_tc",    32'(tc_a),    (i == 9) ? 1 : 0);
    end

    // Load above MAX_VAL on a tick cycle clamps and suppresses the pulse
    applyStimulus(0, 1, 1, 4'd15, 3'd7, 2'b00, 0);
    checkOutput("load_clamp_count", 32'(count_a), 9);
    checkOutput("load_clamp_tc",    32'(tc_a),    0);
    applyStimulus(0, 1, 0, 4'd0, 3'd0, 2'b00, 0);
    checkOutput("after_load_count", 32'(count_a), 0);
    applyStimulus(1, 1, 1, 4'd7, 3'd3, 2'b00, 0);
    checkOutput("rst_over_load", 32'(count_a), 0);

    // UP_SAT: climbs to 9, one pulse, then holds silently
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(0, 1, 0, 4'd0, 3'd0, 2'b10, 0);
      checkOutput("upsat_count", 32'(count_a), (i < 9) ? i : 9);
      checkOutput("upsat_tc",    32'(tc_a),    (i == 9) ? 1 : 0);
    end

    // PINGPONG from 0 after reset: 1..9..0..1
    applyStimulus(1, 0, 0, 4'd0, 3'd0, 2'b11, 0);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(0, 1, 0, 4'd0, 3'd0, 2'b11, 0);
      p = i % 18;
      exp_cnt = (p <= 9) ? p : 18 - p;
      checkOutput("pp_count", 32'(count_a), exp_cnt);
      checkOutput("pp_dir",   32'(dir_a),   (p >= 9) ? 1 : 0);
      checkOutput("pp_tc",    32'(tc_a),    (p == 9 || p == 0) ? 1 : 0);
    end

    // Randomised phase checked by the models
    cur_mode = 2'b00;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) cur_mode = 2'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 249) == 0,
                    $urandom_range(0, 7) != 0,
                    $urandom_range(0, 29) == 0,
                    4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)),
                    cur_mode,
                    $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
